// File: rtl/intra_pred_pkg.sv
// Shared types and helpers for the NxN intra-prediction engine.
package intra_pred_pkg;

    typedef enum logic [1:0] {
        MODE_DC     = 2'd0,
        MODE_PLANAR = 2'd1,
        MODE_HOR    = 2'd2,
        MODE_VER    = 2'd3
    } intra_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_EMIT = 2'd3
    } intra_state_e;

    localparam int MAX_PIX_W = 12;

    // Mid-grey used when no neighbours exist at all.
    function automatic logic [MAX_PIX_W-1:0] dc_default(input int pix_w);
        return MAX_PIX_W'(1) << (pix_w - 1);
    endfunction

    function automatic bit blk_legal(input int blk);
        return (blk == 4) || (blk == 8) || (blk == 16) || (blk == 32);
    endfunction

    // Directional/planar modes degrade to DC when the neighbours they need are missing.
    function automatic intra_mode_e eff_mode(input logic [1:0] mode,
                                             input logic       top_av,
                                             input logic       left_av);
        intra_mode_e m;
        m = intra_mode_e'(mode);
        case (m)
            MODE_PLANAR: if (!(top_av && left_av)) m = MODE_DC;
            MODE_HOR:    if (!left_av)             m = MODE_DC;
            MODE_VER:    if (!top_av)              m = MODE_DC;
            default:     m = MODE_DC;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/intra_row_gen.sv
// Combinational generator for one predicted row; holds the planar multipliers.
module intra_row_gen
    import intra_pred_pkg::*;
#(
    parameter int BLK      = 4,
    parameter int PIX_W    = 8,
    parameter int LOG2_BLK = $clog2(BLK)
) (
    input  intra_mode_e                   mode,
    input  logic [LOG2_BLK-1:0]           y,
    input  logic [BLK-1:0][PIX_W-1:0]     top,
    input  logic [BLK-1:0][PIX_W-1:0]     left,
    input  logic [PIX_W-1:0]              dc,
    output logic [BLK*PIX_W-1:0]          row
);

    // Each weighted pair is at most BLK*(2^PIX_W-1), so HW bits hold it exactly.
    localparam int HW = PIX_W + LOG2_BLK;

    logic [PIX_W-1:0]    left_y;
    logic [LOG2_BLK-1:0] y_inv;

    assign left_y = left[y];
    // BLK is a power of two, so BLK-1-y is just the bitwise inverse of y.
    assign y_inv  = ~y;

    for (genvar x = 0; x < BLK; x++) begin : g_pix
        logic [HW-1:0]    hor;
        logic [HW-1:0]    ver;
        logic [HW:0]      acc;
        logic [PIX_W-1:0] planar;
        logic [PIX_W-1:0] pix;

        // Planar blend at full precision; only the final shift narrows the result.
        always_comb begin
            hor    = HW'(BLK - 1 - x) * HW'(left_y) + HW'(x + 1) * HW'(top[BLK-1]);
            ver    = HW'(y_inv) * HW'(top[x]) + (HW'(y) + HW'(1)) * HW'(left[BLK-1]);
            acc    = (HW+1)'(hor) + (HW+1)'(ver) + (HW+1)'(BLK);
            planar = PIX_W'(acc >> (LOG2_BLK + 1));
        end

        // Select this pixel according to the effective mode.
        always_comb begin
            pix = dc;
            case (mode)
                MODE_PLANAR: pix = planar;
                MODE_HOR:    pix = left_y;
                MODE_VER:    pix = top[x];
                default:     pix = dc;
            endcase
        end

        assign row[x*PIX_W +: PIX_W] = pix;
    end

endmodule

// File: rtl/intra_pred_engine.sv
// Sequential NxN intra-prediction engine: command, neighbour load, DC calc, row emit.
module intra_pred_engine
    import intra_pred_pkg::*;
#(
    parameter int BLK      = 4,
    parameter int PIX_W    = 8,
    parameter int LOG2_BLK = $clog2(BLK)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [1:0]              cfg_mode,
    input  logic                    cfg_top_avail,
    input  logic                    cfg_left_avail,
    input  logic                    nb_valid,
    output logic                    nb_ready,
    input  logic [PIX_W-1:0]        nb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLK*PIX_W-1:0]    out_row,
    output logic [LOG2_BLK-1:0]     out_row_idx,
    output logic                    out_last,
    output logic                    busy
);

    localparam int SUM_W = PIX_W + LOG2_BLK + 1;
    localparam int CNT_W = LOG2_BLK + 2;   // must reach 2*BLK
    localparam int ROW_W = BLK * PIX_W;

    if (!blk_legal(BLK) || PIX_W < 8 || PIX_W > 12 || LOG2_BLK != $clog2(BLK)) begin : g_bad_cfg
        $error("intra_pred_engine: illegal BLK/PIX_W/LOG2_BLK");
    end

    intra_state_e              state_q, state_d;
    intra_mode_e               mode_q, mode_d;
    logic                      top_av_q, top_av_d;
    logic                      left_av_q, left_av_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [PIX_W-1:0]          dc_q, dc_d;
    logic [LOG2_BLK-1:0]       y_q, y_d;
    logic [BLK-1:0][PIX_W-1:0] top_q, top_d;
    logic [BLK-1:0][PIX_W-1:0] left_q, left_d;
    logic [ROW_W-1:0]          row_q, row_d;

    logic [CNT_W-1:0]          beats_total;
    logic                      last_beat;
    logic [PIX_W-1:0]          dc_calc;
    logic [PIX_W-1:0]          gen_dc;
    logic [LOG2_BLK-1:0]       gen_y;
    logic [ROW_W-1:0]          gen_row;

    assign beats_total = (top_av_q  ? CNT_W'(BLK) : CNT_W'(0))
                       + (left_av_q ? CNT_W'(BLK) : CNT_W'(0));
    assign last_beat   = (cnt_q + CNT_W'(1)) == beats_total;

    // Rounded mean of whatever neighbours were loaded; mid-grey when none.
    always_comb begin
        dc_calc = PIX_W'(dc_default(PIX_W));
        if (cnt_q == CNT_W'(BLK))
            dc_calc = PIX_W'((sum_q + SUM_W'(BLK / 2)) >> LOG2_BLK);
        else if (cnt_q == CNT_W'(2 * BLK))
            dc_calc = PIX_W'((sum_q + SUM_W'(BLK)) >> (LOG2_BLK + 1));
    end

    // In CALC the generator sees the fresh DC and row 0; in EMIT it prepares row y+1.
    assign gen_dc = (state_q == ST_CALC) ? dc_calc : dc_q;
    assign gen_y  = (state_q == ST_CALC) ? '0 : y_q + LOG2_BLK'(1);

    intra_row_gen #(
        .BLK      (BLK),
        .PIX_W    (PIX_W),
        .LOG2_BLK (LOG2_BLK)
    ) u_row_gen (
        .mode (mode_q),
        .y    (gen_y),
        .top  (top_q),
        .left (left_q),
        .dc   (gen_dc),
        .row  (gen_row)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cfg_valid)
                         state_d = (cfg_top_avail || cfg_left_avail) ? ST_LOAD : ST_CALC;
            ST_LOAD: if (nb_valid && last_beat) state_d = ST_CALC;
            ST_CALC: state_d = ST_EMIT;
            ST_EMIT: if (out_ready && y_q == LOG2_BLK'(BLK - 1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decode directly from state.
    always_comb begin
        cfg_ready   = (state_q == ST_IDLE);
        nb_ready    = (state_q == ST_LOAD);
        out_valid   = (state_q == ST_EMIT);
        busy        = (state_q != ST_IDLE);
        out_last    = (state_q == ST_EMIT) && (y_q == LOG2_BLK'(BLK - 1));
        out_row     = row_q;
        out_row_idx = y_q;
    end

    // Datapath next values: command latch, neighbour capture, DC, row advance.
    always_comb begin
        mode_d    = mode_q;
        top_av_d  = top_av_q;
        left_av_d = left_av_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        dc_d      = dc_q;
        y_d       = y_q;
        top_d     = top_q;
        left_d    = left_q;
        row_d     = row_q;
        case (state_q)
            ST_IDLE: if (cfg_valid) begin
                mode_d    = eff_mode(cfg_mode, cfg_top_avail, cfg_left_avail);
                top_av_d  = cfg_top_avail;
                left_av_d = cfg_left_avail;
                cnt_d     = '0;
                sum_d     = '0;
            end
            ST_LOAD: if (nb_valid) begin
                // Top pixels arrive first when present, then left.
                if (top_av_q && cnt_q < CNT_W'(BLK))
                    top_d[cnt_q[LOG2_BLK-1:0]]  = nb_data;
                else
                    left_d[cnt_q[LOG2_BLK-1:0]] = nb_data;
                sum_d = sum_q + SUM_W'(nb_data);
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_CALC: begin
                dc_d  = dc_calc;
                y_d   = '0;
                row_d = gen_row;
            end
            ST_EMIT: if (out_ready && y_q != LOG2_BLK'(BLK - 1)) begin
                y_d   = y_q + LOG2_BLK'(1);
                row_d = gen_row;
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_DC;
            top_av_q  <= 1'b0;
            left_av_q <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            dc_q      <= '0;
            y_q       <= '0;
            top_q     <= '0;
            left_q    <= '0;
            row_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            top_av_q  <= top_av_d;
            left_av_q <= left_av_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            dc_q      <= dc_d;
            y_q       <= y_d;
            top_q     <= top_d;
            left_q    <= left_d;
            row_q     <= row_d;
        end
    end

endmodule

// File: tb/tb_intra_pred_engine.sv
// Scoreboard bench for intra_pred_engine at BLK=4, PIX_W=8.
module tb_intra_pred_engine;

    localparam int BLK      = 4;
    localparam int PIX_W    = 8;
    localparam int LOG2_BLK = 2;
    localparam int ROW_W    = BLK * PIX_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [1:0]           cfg_mode = 2'd0;
    logic                 cfg_top_avail = 1'b0;
    logic                 cfg_left_avail = 1'b0;
    logic                 nb_valid = 1'b0;
    logic                 nb_ready;
    logic [PIX_W-1:0]     nb_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ROW_W-1:0]     out_row;
    logic [LOG2_BLK-1:0]  out_row_idx;
    logic                 out_last;
    logic                 busy;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    intra_pred_engine #(.BLK(BLK), .PIX_W(PIX_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_mode       (cfg_mode),
        .cfg_top_avail  (cfg_top_avail),
        .cfg_left_avail (cfg_left_avail),
        .nb_valid       (nb_valid),
        .nb_ready       (nb_ready),
        .nb_data        (nb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_row        (out_row),
        .out_row_idx    (out_row_idx),
        .out_last       (out_last),
        .busy           (busy)
    );

    typedef struct {
        logic [ROW_W-1:0]    row;
        logic [LOG2_BLK-1:0] idx;
        logic                last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   hs_cyc = 0, first_cyc = 0, nb_beats = 0;
    int   stall_idx = -1, stall_left = 0;
    bit   seen = 0, nb_seen = 0;
    int   t[4], l[4], px[8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected rows for one command.
    task automatic push_exp(input int mode, input bit ta, input bit la);
        int em, sum, cnt, dc, p;
        exp_t x;
        em = mode;
        if (mode == 1 && !(ta && la)) em = 0;
        if (mode == 2 && !la) em = 0;
        if (mode == 3 && !ta) em = 0;
        sum = 0; cnt = 0;
        if (ta) for (int i = 0; i < 4; i++) begin sum += t[i]; cnt++; end
        if (la) for (int i = 0; i < 4; i++) begin sum += l[i]; cnt++; end
        dc = (cnt == 0) ? 128 : (cnt == 4) ? (sum + 2) / 4 : (sum + 4) / 8;
        for (int y = 0; y < 4; y++) begin
            x.row = '0;
            for (int c = 0; c < 4; c++) begin
                case (em)
                    1: p = ((3 - c) * l[y] + (c + 1) * t[3] + (3 - y) * t[c] + (y + 1) * l[3] + 4) / 8;
                    2: p = l[y];
                    3: p = t[c];
                    default: p = dc;
                endcase
                x.row[c*8 +: 8] = 8'(p);
            end
            x.idx  = 2'(y);
            x.last = (y == 3);
            sb.push_back(x);
        end
    endtask

    task automatic send_cmd(input int mode, input bit ta, input bit la);
        int k = 0;
        cfg_valid = 1'b1; cfg_mode = 2'(mode); cfg_top_avail = ta; cfg_left_avail = la;
        @(negedge clk);
        while (!cfg_ready && k < 100) begin @(negedge clk); k++; end
        chk("cmd_accept", cfg_ready, 1);
        hs_cyc = cyc;
        seen   = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_nb(input int n, input bit gap);
        int k;
        for (int i = 0; i < n; i++) begin
            nb_valid = 1'b1; nb_data = 8'(px[i]);
            k = 0;
            @(negedge clk);
            while (!nb_ready && k < 100) begin @(negedge clk); k++; end
            chk("nb_accept", nb_ready, 1);
            @(posedge clk); #1;
            nb_valid = 1'b0;
            if (gap) begin @(posedge clk); #1; end
        end
        nb_valid = 1'b0;
    endtask

    task automatic run(input int mode, input bit ta, input bit la, input bit gap);
        int n = 0;
        if (ta) for (int i = 0; i < 4; i++) begin px[n] = t[i]; n++; end
        if (la) for (int i = 0; i < 4; i++) begin px[n] = l[i]; n++; end
        push_exp(mode, ta, la);
        send_cmd(mode, ta, la);
        send_nb(n, gap);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && k < 300) begin @(negedge clk); k++; end
        chk("drain_busy", busy, 0);
        chk("drain_sb", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Output monitor: applies stall pattern, pops scoreboard on each accepted row.
    always @(negedge clk) begin
        if (rst_n) begin
            if (nb_ready) nb_seen = 1;
            if (nb_valid && nb_ready) nb_beats++;
            if (out_valid) begin
                if (!seen) begin seen = 1; first_cyc = cyc; end
                if (stall_left > 0 && int'(out_row_idx) == stall_idx) begin
                    out_ready = 1'b0;
                    stall_left--;
                    if (sb.size() > 0) begin
                        chk("stall_row", out_row, sb[0].row);
                        chk("stall_idx", out_row_idx, sb[0].idx);
                    end
                end else begin
                    out_ready = 1'b1;
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("row", out_row, e.row);
                        chk("row_idx", out_row_idx, e.idx);
                        chk("last", out_last, e.last);
                    end
                end
            end else if (out_last) begin
                chk("last_idle", out_last, 0);
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_nb_ready", nb_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_row_idx", out_row_idx, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // DC, both sides: 75 everywhere, 8 beats, 2*BLK+2 latency
        t = '{100, 100, 100, 100}; l = '{50, 50, 50, 50};
        nb_beats = 0;
        run(0, 1, 1, 0);
        wait_idle();
        chk("dc_both_beats", nb_beats, 8);
        chk("dc_both_lat", first_cyc - hs_cyc, 10);

        // DC, top only: sum 101 -> 25
        t = '{10, 20, 30, 41};
        run(0, 1, 0, 0);
        chk("nb_ready_after_last", nb_ready, 0);
        wait_idle();

        // DC, no neighbours: mid-grey, no load phase
        nb_seen = 0;
        run(0, 0, 0, 0);
        wait_idle();
        chk("none_nb_ready", nb_seen, 0);
        chk("none_lat", first_cyc - hs_cyc, 2);

        // Planar extremes, fallback, and a gradient loaded with gaps
        t = '{255, 255, 255, 255}; l = '{255, 255, 255, 255};
        run(1, 1, 1, 0);
        wait_idle();
        t = '{200, 200, 200, 200}; l = '{200, 200, 200, 200};
        run(1, 1, 1, 0);
        wait_idle();
        t = '{10, 20, 30, 41};
        run(1, 1, 0, 0);
        wait_idle();
        t = '{10, 50, 90, 130}; l = '{20, 60, 100, 140};
        run(1, 1, 1, 1);
        wait_idle();

        // Vertical with a 3-cycle stall on row 2
        t = '{1, 2, 3, 4};
        stall_idx = 2; stall_left = 3;
        run(3, 1, 0, 0);
        wait_idle();
        chk("stall_used", stall_left, 0);

        // Reset during LOAD, then horizontal with left only
        t = '{7, 7, 7, 7}; l = '{7, 7, 7, 7};
        px = '{7, 7, 7, 7, 7, 7, 7, 7};
        send_cmd(0, 1, 1);
        send_nb(3, 0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_nb_ready", nb_ready, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        l = '{9, 8, 7, 6};
        run(2, 0, 1, 0);
        wait_idle();
        chk("final_cfg_ready", cfg_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intra_pred_engine.md
Name: intra_pred_engine

Overview:
Parametrised, sequential NxN intra-prediction engine for the camera decoder prediction module. It accepts a command (mode plus neighbour availability) and streams in the available neighbour pixels. It then emits the predicted block one row per cycle under valid/ready backpressure. It generalises the fixed 4x4 combinational predictor to configurable block size and pixel width, and adds horizontal and vertical modes, rounding DC and overflow-safe planar arithmetic.

Parameters:
BLK, 4, block edge in pixels; legal values 4, 8, 16, 32 (power of two).
PIX_W, 8, pixel bit width; 8 to 12.
LOG2_BLK, $clog2(BLK), derived; not overridden.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  command valid
cfg_ready  out  1  command accepted when high with cfg_valid; high only in IDLE
cfg_mode  in  2  0=DC, 1=planar, 2=horizontal, 3=vertical
cfg_top_avail  in  1  top neighbours present
cfg_left_avail  in  1  left neighbours present
nb_valid  in  1  neighbour pixel valid
nb_ready  out  1  neighbour pixel accepted; high only in LOAD
nb_data  in  PIX_W  neighbour pixel; order is top[0..BLK-1], then left[0..BLK-1]; only available sides are sent
out_valid  out  1  predicted row valid
out_ready  in  1  downstream accepts row
out_row  out  BLK*PIX_W  row pixels; pixel x at bits [x*PIX_W +: PIX_W]
out_row_idx  out  LOG2_BLK  row index y
out_last  out  1  high with row BLK-1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE; cfg_ready=1, nb_ready=0, out_valid=0, out_last=0, busy=0; out_row=0, out_row_idx=0; neighbour registers, accumulator and counters cleared.
- IDLE: on cfg_valid&&cfg_ready, latch mode and availability flags, and compute the effective mode:
  - planar without both sides -> DC;
  - horizontal without left -> DC;
  - vertical without top -> DC.
  - Then go to LOAD. If neither side is available, skip LOAD and go to CALC.
- LOAD: nb_ready=1. Each nb_valid&&nb_ready beat writes the next neighbour register and adds the pixel to the sum accumulator (PIX_W+LOG2_BLK+1 bits). Beat count is BLK×(top+left). The cycle after the final beat, go to CALC. Gaps on nb_valid are allowed and stall the count.
- CALC: one cycle. Register the DC value and go to EMIT with y=0.
  - cnt=BLK: DC=(sum+BLK/2)>>LOG2_BLK.
  - cnt=2BLK: DC=(sum+BLK)>>(LOG2_BLK+1).
  - cnt=0: DC=1<<(PIX_W-1).
- EMIT: out_valid=1 while row y is presented.
  - out_row, out_row_idx and out_last stay stable until out_valid&&out_ready.
  - On handshake, y increments. After row BLK-1, go to IDLE; cfg_ready is high in the next cycle.
  - Rows are registered outputs: the first row is valid the cycle after CALC.
- Row generation (pixel x of row y):
  - DC: every pixel = DC value.
  - Vertical: top[x].
  - Horizontal: left[y].
  - Planar: hor=(BLK-1-x)*left[y]+(x+1)*top[BLK-1]; ver=(BLK-1-y)*top[x]+(y+1)*left[BLK-1]; pred=(hor+ver+BLK)>>(LOG2_BLK+1).
  - hor and ver are each PIX_W+LOG2_BLK bits; the sum is one bit wider. No truncation before the shift; the result always fits PIX_W.
- Minimum latency from command handshake to first out_valid (both sides available, no stalls): 2·BLK+2 cycles. Throughput is one row per cycle with out_ready held high.
- cfg_valid is ignored outside IDLE; no queuing. nb_valid outside LOAD is ignored; nb_ready=0.
- Illegal BLK/PIX_W values are rejected by an elaboration-time assertion.

Decomposition:
- Package intra_pred_pkg:
  - intra_mode_e (DC, PLANAR, HOR, VER);
  - state enum (IDLE, LOAD, CALC, EMIT);
  - function dc_default(PIX_W);
  - legal-BLK check function.
- Sub-module intra_row_gen (combinational): takes effective mode, y, neighbour arrays and DC value; returns one row of BLK pixels. It holds the planar multipliers so the FSM stays in intra_pred_engine.

Test Plan:
1. BLK=4, DC, both available, top=100×4, left=50×4 -> 8 beats consumed; 4 rows of all 75; out_last only on row 3.
2. DC, top only, top={10,20,30,41} -> 4 beats (sum 101); all pixels 25; nb_ready low after 4th beat.
3. Mode 0, neither available -> nb_ready never asserts; 4 rows of 128; first out_valid 2 cycles after command handshake.
4. Planar, both, all neighbours 255 -> every pixel 255 (no overflow). All neighbours 200 -> every pixel 200. Planar with left missing -> falls back to DC of top.
5. Vertical, top={1,2,3,4}; out_ready low for 3 cycles on row 2 -> each row {1,2,3,4}; row 2 data and out_row_idx=2 held stable during the stall; out_last with idx 3.
6. rst_n pulsed low after 3 LOAD beats -> immediately IDLE, cfg_ready=1, out_valid=0, busy=0. A following horizontal command with left={9,8,7,6} yields rows 9s, 8s, 7s, 6s.
